hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Pipeline interlock controller for the 5-stage RISC-V core. Sits beside decode and drives
//  the STALL and DUMP nets consumed by Fetch_Decode_Moderator and Decode_Execute_Moderator.
//  A shift-register scoreboard tracks in-flight destination registers. STALL holds decode on
//  a RAW hazard (no forwarding). DUMP flushes wrong-path instructions after a taken branch or jump.
// PARAMETERS
//  SB_DEPTH      3   stages between decode issue and regfile write (EX, MEM, WB)
//  FLUSH_CYCLES  2   cycles DUMP stays high after an accepted redirect (1..7)
//  PERF_BITS     32  width of the stall-cycle performance counter
// PORTS
//  clock            in   1   single clock, rising edge
//  reset            in   1   asynchronous, active-low (0 = reset)
//  id_valid         in   1   decode holds a real instruction
//  id_rs1           in   5   rs1 index of decode instruction
//  id_rs1_used      in   1   instruction reads rs1
//  id_rs2           in   5   rs2 index
//  id_rs2_used      in   1   instruction reads rs2
//  id_rd            in   5   destination index
//  id_wEn           in   1   instruction writes rd
//  id_redirect      in   1   decode next_PC_select (taken branch / JAL / JALR)
//  STALL            out  1   hold PC, FDM and decode; DEM inserts a bubble
//  DUMP             out  1   squash FDM/DEM contents (wrong path)
//  pending_mask     out  32  bit r set = x[r] has a write in flight (debug)
//  perf_stall_cycles out PERF_BITS  count of cycles with STALL=1
// BEHAVIOUR
//  - Reset (reset=0, async): all scoreboard entries invalid, flush counter 0, perf counter 0.
//    Consequently STALL=0, DUMP=0, pending_mask=0 while in reset and on the first cycle after it.
//  - issue = id_valid & !STALL & !DUMP.
//  - Scoreboard: SB_DEPTH entries {valid, rd}; entry 0 = EX, entry SB_DEPTH-1 = WB.
//    Every clock, entries shift by one unconditionally, because downstream stages never stall.
//    Entry 0 loads {1, id_rd} if issue & id_wEn & id_rd!=0; otherwise it loads a bubble {0, x}.
//    The entry leaving the WB slot retires. Its register reads as valid only from the next cycle.
//  - STALL (combinational) = id_valid & !DUMP & ((id_rs1_used & id_rs1!=0 & match(id_rs1)) |
//    (id_rs2_used & id_rs2!=0 & match(id_rs2))). match(r) is true if any valid entry has rd==r.
//    x0 never stalls.
//  - Load-use and ALU-use are handled the same way. Worst-case stall = SB_DEPTH cycles.
//  - Redirect: accepted when id_redirect & issue. On the next edge, flush_cnt <= FLUSH_CYCLES.
//    DUMP = (flush_cnt != 0). flush_cnt decrements each cycle while nonzero.
//  - Redirect during a hazard: STALL wins. The redirect is accepted only after operands clear,
//    because the branch compare needs valid data.
//  - id_redirect while DUMP=1 is ignored; that instruction is itself squashed.
//  - The redirecting instruction issues normally. If it writes rd (JAL/JALR), a scoreboard
//    entry is pushed for it.
//  - STALL and DUMP are never both 1.
//  - perf_stall_cycles increments when STALL=1 and saturates at all-ones.
//  - pending_mask = OR of one-hot(rd) over valid entries.
//  - Reset asserted mid-stall or mid-flush: outputs drop to 0 asynchronously.
//    No stale entry survives deassertion.
// STRUCTURE
//  - Shared package hazard_pkg: SB_DEPTH default, REG_X0 = 5'd0, typedef sb_entry_t {valid, rd[4:0]}.
//  - Sub-module hazard_scoreboard: the entry shift register with two match ports and the
//    pending_mask output.
//  - hazard_unit adds the stall equation, flush counter and perf counter.
// TESTING
//  1 Reset: hold reset=0 with id_valid=1, id_rs1=5 -> STALL=0, DUMP=0, pending_mask=0,
//    perf_stall_cycles=0.
//  2 ALU-use: issue "add x5" (id_wEn=1, rd=5), then decode reads rs1=5 -> STALL=1 for exactly
//    3 cycles, issues on cycle 4, perf_stall_cycles=3.
//  3 x0 writer/reader: issue rd=0 wEn=1, then read rs1=0 -> STALL never asserts;
//    pending_mask stays 0.
//  4 Taken branch: id_redirect=1 with no hazard -> DUMP=1 for 2 cycles starting next cycle.
//    id_redirect=1 during the DUMP window causes no extension.
//  5 Redirect + hazard: JALR reading rs1=7 while x7 is in MEM -> STALL=1 for 2 cycles, DUMP=0.
//    Redirect accepted on cycle 3, then DUMP=1 for 2 cycles. pending_mask includes the JALR rd.
//  6 Async reset mid-flush: assert reset=0 between edges while DUMP=1 and pending_mask=32'h20
//    -> both read 0 immediately; after release, reading x5 gives STALL=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode interlock: scoreboard entry layout,
// default pipeline depth and the hard-wired zero register.
package hazard_pkg;

  localparam int unsigned SB_DEPTH_DEFAULT = 3;
  localparam int unsigned FLUSH_W          = 3;
  localparam logic [4:0]  REG_X0           = 5'd0;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } sb_entry_t;

endpackage

// File: rtl/hazard_unit_if.sv
// Decode <-> interlock bundle: decode-stage operand/destination info in,
// STALL/DUMP control and debug/perf observability out.
interface hazard_unit_if #(
  parameter int unsigned PERF_BITS = 32
);
  logic                 id_valid;
  logic [4:0]           id_rs1;
  logic                 id_rs1_used;
  logic [4:0]           id_rs2;
  logic                 id_rs2_used;
  logic [4:0]           id_rd;
  logic                 id_wEn;
  logic                 id_redirect;
  logic                 STALL;
  logic                 DUMP;
  logic [31:0]          pending_mask;
  logic [PERF_BITS-1:0] perf_stall_cycles;

  modport master (
    output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd, id_wEn, id_redirect,
    input  STALL, DUMP, pending_mask, perf_stall_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd, id_wEn, id_redirect,
    output STALL, DUMP, pending_mask, perf_stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// In-flight destination tracker: one entry per stage from EX to WB, shifted every
// clock since downstream stages never stall. Two read ports look up decode operands.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned SB_DEPTH = SB_DEPTH_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_push_valid,
  input  logic [4:0]  i_push_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  output logic        o_match1,
  output logic        o_match2,
  output logic [31:0] o_pending_mask
);

  sb_entry_t [SB_DEPTH-1:0] r_sb;

  // Entry SB_DEPTH-1 (WB) simply falls off the end; its register is readable next cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sb <= '0;
    end else begin
      r_sb[0].valid <= i_push_valid;
      r_sb[0].rd    <= i_push_valid ? i_push_rd : REG_X0;
      for (int i = 1; i < SB_DEPTH; i++) begin
        r_sb[i] <= r_sb[i-1];
      end
    end
  end

  always_comb begin
    o_match1       = 1'b0;
    o_match2       = 1'b0;
    o_pending_mask = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (r_sb[i].valid) begin
        if (r_sb[i].rd == i_rs1) o_match1 = 1'b1;
        if (r_sb[i].rd == i_rs2) o_match2 = 1'b1;
        o_pending_mask[r_sb[i].rd] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline interlock: RAW stall against the scoreboard, wrong-path DUMP window after
// an accepted redirect, and a saturating stall-cycle counter.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned SB_DEPTH     = SB_DEPTH_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned PERF_BITS    = 32
) (
  input logic          clock,
  input logic          reset,
  hazard_unit_if.slave bus
);

  logic                 w_match1;
  logic                 w_match2;
  logic                 w_hazard;
  logic                 w_stall;
  logic                 w_dump;
  logic                 w_issue;
  logic                 w_push;
  logic [31:0]          w_pending;
  logic [FLUSH_W-1:0]   r_flush_cnt;
  logic [PERF_BITS-1:0] r_perf;

  assign w_dump   = (r_flush_cnt != '0);
  assign w_hazard = (bus.id_rs1_used && (bus.id_rs1 != REG_X0) && w_match1) ||
                    (bus.id_rs2_used && (bus.id_rs2 != REG_X0) && w_match2);
  // DUMP masks STALL: a squashed instruction must not hold up the pipe.
  assign w_stall  = bus.id_valid && !w_dump && w_hazard;
  assign w_issue  = bus.id_valid && !w_stall && !w_dump;
  assign w_push   = w_issue && bus.id_wEn && (bus.id_rd != REG_X0);

  hazard_scoreboard #(
    .SB_DEPTH(SB_DEPTH)
  ) u_sb (
    .clock         (clock),
    .reset         (reset),
    .i_push_valid  (w_push),
    .i_push_rd     (bus.id_rd),
    .i_rs1         (bus.id_rs1),
    .i_rs2         (bus.id_rs2),
    .o_match1      (w_match1),
    .o_match2      (w_match2),
    .o_pending_mask(w_pending)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_flush_cnt <= '0;
    end else if (w_issue && bus.id_redirect) begin
      r_flush_cnt <= FLUSH_W'(FLUSH_CYCLES);
    end else if (w_dump) begin
      r_flush_cnt <= r_flush_cnt - FLUSH_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_perf <= '0;
    end else if (w_stall && (r_perf != '1)) begin
      r_perf <= r_perf + PERF_BITS'(1);
    end
  end

  assign bus.STALL             = w_stall;
  assign bus.DUMP              = w_dump;
  assign bus.pending_mask      = w_pending;
  assign bus.perf_stall_cycles = r_perf;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit: the driver queues the expected outputs for each
// cycle, and a separate monitor pops and compares them on the falling edge.
module tb_hazard_unit;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic chk_tgl = 1'b0;

  always #5 clock = ~clock;

  hazard_unit_if #(.PERF_BITS(32)) bus ();

  hazard_unit u_dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [63:0] name;
    logic        stall;
    logic        dump;
    logic [31:0] mask;
    bit          chk_perf;
    logic [31:0] perf;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cmp(input logic [63:0] nm, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
    end
  endtask

  // Monitor: falling edge, or an explicit mid-cycle sample request.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock or chk_tgl);
      if (q.size() != 0) begin
        e = q.pop_front();
        cmp(e.name, "STALL", {31'd0, bus.STALL}, {31'd0, e.stall});
        cmp(e.name, "DUMP", {31'd0, bus.DUMP}, {31'd0, e.dump});
        cmp(e.name, "mask", bus.pending_mask, e.mask);
        if (e.chk_perf) cmp(e.name, "perf", bus.perf_stall_cycles, e.perf);
      end
    end
  end

  task automatic drv(input logic v, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                     input logic w, input logic rdr);
    bus.id_valid    = v;
    bus.id_rs1      = rs1;
    bus.id_rs1_used = u1;
    bus.id_rs2      = rs2;
    bus.id_rs2_used = u2;
    bus.id_rd       = rd;
    bus.id_wEn      = w;
    bus.id_redirect = rdr;
  endtask

  task automatic ex(input logic [63:0] nm, input logic st, input logic du,
                    input logic [31:0] m, input bit cp, input logic [31:0] p);
    exp_t e;
    e.name = nm; e.stall = st; e.dump = du; e.mask = m; e.chk_perf = cp; e.perf = p;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    idle();
    tick();

    // 1: reset holds everything at zero even with a would-be hazard on the inputs
    drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    ex("rst0", 0, 0, 32'h0, 1, 32'd0); tick();
    ex("rst1", 0, 0, 32'h0, 1, 32'd0); tick();
    reset = 1'b1;
    idle();
    ex("rstrel", 0, 0, 32'h0, 1, 32'd0); tick();

    // 2: ALU-use on x5, three stall cycles
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    ex("add_x5", 0, 0, 32'h0, 1, 32'd0); tick();
    drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    ex("use_ex", 1, 0, 32'h20, 1, 32'd0); tick();
    ex("use_mem", 1, 0, 32'h20, 1, 32'd1); tick();
    ex("use_wb", 1, 0, 32'h20, 1, 32'd2); tick();
    ex("use_go", 0, 0, 32'h0, 1, 32'd3); tick();
    idle();
    ex("idle2", 0, 0, 32'h0, 1, 32'd3); tick();

    // 3: x0 never tracked, never stalls
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    ex("wr_x0", 0, 0, 32'h0, 0, 32'd0); tick();
    drv(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    ex("rd_x0", 0, 0, 32'h0, 0, 32'd0); tick();
    idle();
    ex("x0_idle", 0, 0, 32'h0, 1, 32'd3); tick();

    // 4: taken branch, redirects inside the window are ignored and squashed
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    ex("br", 0, 0, 32'h0, 0, 32'd0); tick();
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    ex("dump1", 0, 1, 32'h0, 0, 32'd0); tick();
    ex("dump2", 0, 1, 32'h0, 0, 32'd0); tick();
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    ex("noext", 0, 0, 32'h0, 0, 32'd0); tick();

    // 5: JALR x1 <- x7 while x7 is in MEM
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    ex("wr_x7", 0, 0, 32'h0, 0, 32'd0); tick();
    idle();
    ex("bubble", 0, 0, 32'h80, 0, 32'd0); tick();
    drv(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1);
    ex("jalr_s1", 1, 0, 32'h80, 1, 32'd3); tick();
    ex("jalr_s2", 1, 0, 32'h80, 1, 32'd4); tick();
    ex("jalr_go", 0, 0, 32'h0, 1, 32'd5); tick();
    drv(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    ex("jdump1", 0, 1, 32'h2, 1, 32'd5); tick();
    ex("jdump2", 0, 1, 32'h2, 1, 32'd5); tick();
    idle();
    ex("jwb", 0, 0, 32'h2, 0, 32'd0); tick();
    ex("jdone", 0, 0, 32'h0, 1, 32'd5); tick();

    // 6: async reset in the middle of a flush with x5 pending
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    ex("j_x5", 0, 0, 32'h0, 0, 32'd0); tick();
    idle();
    ex("preRst", 0, 1, 32'h20, 1, 32'd5);
    #6;
    reset = 1'b0;
    #1;
    ex("asyncR", 0, 0, 32'h0, 1, 32'd0);
    chk_tgl = ~chk_tgl;
    tick();
    reset = 1'b1;
    drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    ex("postRst", 0, 0, 32'h0, 1, 32'd0); tick();
    idle();
    ex("end", 0, 0, 32'h0, 1, 32'd0); tick();

    for (int i = 0; i < 5 && q.size() != 0; i++) tick();
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
